cpu_run_ctrl: RTL and testbench

Run/step sequencer for the MIPS 5-stage pipeline CPU. It turns the debug-mode switch, the step button and the interrupt button into a registered pipeline clock-enable (`cpu_en`) and a request/acknowledge interrupt line. It supports:
- free run,
- halt,
- single step,
- N-cycle burst stepping.

The block sits between the button scanner/switches and the CPU core, in the `clk_cpu` domain.

---
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: turns debug switch, step and interrupt buttons into a
// pipeline clock-enable, an interrupt request/ack line and activity counters.
module cpu_run_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             debug_en,
   input  logic             step_btn,
   input  logic             int_btn,
   input  logic             burst_en,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             int_ack,
   output logic             cpu_en,
   output logic             int_req,
   output logic             halted,
   output logic [31:0]      cycle_cnt,
   output logic [7:0]       int_drop
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HALT  = 2'd1;
   localparam logic [1:0] ST_STEP  = 2'd2;
   localparam logic [1:0] ST_BURST = 2'd3;

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   logic             step_sync1_r;
   logic             step_sync2_r;
   logic             step_prev_r;
   logic             int_sync1_r;
   logic             int_sync2_r;
   logic             int_prev_r;
   logic             step_rise_s;
   logic             int_rise_s;

   logic             int_req_r;
   logic             int_req_nxt_s;
   logic [7:0]       int_drop_r;
   logic [7:0]       int_drop_nxt_s;
   logic [31:0]      cycle_cnt_r;
   logic             cpu_en_s;

   assign step_rise_s = step_sync2_r & ~step_prev_r;
   assign int_rise_s  = int_sync2_r & ~int_prev_r;
   assign cpu_en_s    = (state_r != ST_HALT);

   // Run-state sequencing; dropping debug_en always wins and discards any burst
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (!debug_en) begin
         state_nxt_s = ST_RUN;
         cnt_nxt_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_RUN: begin
               state_nxt_s = ST_HALT;
            end
            ST_HALT: begin
               if (step_rise_s) begin
                  if (burst_en && (burst_len > CNT_W'(1))) begin
                     state_nxt_s = ST_BURST;
                     cnt_nxt_s   = burst_len;
                  end else begin
                     state_nxt_s = ST_STEP;
                  end
               end else begin
                  state_nxt_s = ST_HALT;
               end
            end
            ST_STEP: begin
               state_nxt_s = ST_HALT;
            end
            ST_BURST: begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  state_nxt_s = ST_HALT;
               end else begin
                  state_nxt_s = ST_BURST;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Interrupt request: a new edge re-arms even when acked in the same cycle
   always_comb begin
      int_req_nxt_s  = int_req_r;
      int_drop_nxt_s = int_drop_r;
      if (int_rise_s) begin
         int_req_nxt_s = 1'b1;
         if (int_req_r && !int_ack && (int_drop_r != 8'hFF)) begin
            int_drop_nxt_s = int_drop_r + 8'd1;
         end else begin
            int_drop_nxt_s = int_drop_r;
         end
      end else if (int_ack) begin
         int_req_nxt_s = 1'b0;
      end else begin
         int_req_nxt_s = int_req_r;
      end
   end

   // State, synchronisers and counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_RUN;
         cnt_r        <= {CNT_W{1'b0}};
         step_sync1_r <= 1'b0;
         step_sync2_r <= 1'b0;
         step_prev_r  <= 1'b0;
         int_sync1_r  <= 1'b0;
         int_sync2_r  <= 1'b0;
         int_prev_r   <= 1'b0;
         int_req_r    <= 1'b0;
         int_drop_r   <= 8'd0;
         cycle_cnt_r  <= 32'd0;
      end else begin
         state_r      <= state_nxt_s;
         cnt_r        <= cnt_nxt_s;
         step_sync1_r <= step_btn;
         step_sync2_r <= step_sync1_r;
         step_prev_r  <= step_sync2_r;
         int_sync1_r  <= int_btn;
         int_sync2_r  <= int_sync1_r;
         int_prev_r   <= int_sync2_r;
         int_req_r    <= int_req_nxt_s;
         int_drop_r   <= int_drop_nxt_s;
         if (cpu_en_s) begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
         end else begin
            cycle_cnt_r <= cycle_cnt_r;
         end
      end
   end

   assign cpu_en    = cpu_en_s;
   assign halted    = (state_r == ST_HALT);
   assign int_req   = int_req_r;
   assign int_drop  = int_drop_r;
   assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed plus randomized bench for cpu_run_ctrl against a behavioural model
// that tracks "free running" vs "debug with N enabled cycles still owed".
module tb_cpu_run_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             debug_en;
   logic             step_btn;
   logic             int_btn;
   logic             burst_en;
   logic [CNT_W-1:0] burst_len;
   logic             int_ack;
   logic             cpu_en;
   logic             int_req;
   logic             halted;
   logic [31:0]      cycle_cnt;
   logic [7:0]       int_drop;

   int tests = 0;
   int fails = 0;
   int en_cnt = 0;

   // Reference model state
   logic        m_dbg;
   int          m_rem;
   logic [31:0] m_cyc;
   logic        m_req;
   int          m_drop;
   logic [2:0]  m_sh;
   logic [2:0]  m_ih;

   cpu_run_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .debug_en  (debug_en),
      .step_btn  (step_btn),
      .int_btn   (int_btn),
      .burst_en  (burst_en),
      .burst_len (burst_len),
      .int_ack   (int_ack),
      .cpu_en    (cpu_en),
      .int_req   (int_req),
      .halted    (halted),
      .cycle_cnt (cycle_cnt),
      .int_drop  (int_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_dbg  = 1'b0;
      m_rem  = 0;
      m_cyc  = 32'd0;
      m_req  = 1'b0;
      m_drop = 0;
      m_sh   = 3'b000;
      m_ih   = 3'b000;
   endtask

   // m_sh[0..2] hold the button samples from 1, 2 and 3 edges ago
   task automatic model_edge();
      logic s_rise;
      logic i_rise;
      s_rise = m_sh[1] & ~m_sh[2];
      i_rise = m_ih[1] & ~m_ih[2];
      if (!m_dbg || m_rem > 0) m_cyc = m_cyc + 32'd1;
      if (!debug_en) begin
         m_dbg = 1'b0;
         m_rem = 0;
      end else if (!m_dbg) begin
         m_dbg = 1'b1;
         m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem = m_rem - 1;
      end else if (s_rise) begin
         m_rem = (burst_en && burst_len > 1) ? int'(burst_len) : 1;
      end
      if (i_rise) begin
         if (m_req && !int_ack && m_drop < 255) m_drop = m_drop + 1;
         m_req = 1'b1;
      end else if (int_ack) begin
         m_req = 1'b0;
      end
      m_sh = {m_sh[1:0], step_btn};
      m_ih = {m_ih[1:0], int_btn};
   endtask

   task automatic check_all();
      check("cpu_en",    {31'd0, cpu_en},  {31'd0, (!m_dbg || m_rem > 0)});
      check("halted",    {31'd0, halted},  {31'd0, (m_dbg && m_rem == 0)});
      check("int_req",   {31'd0, int_req}, {31'd0, m_req});
      check("cycle_cnt", cycle_cnt, m_cyc);
      check("int_drop",  {24'd0, int_drop}, m_drop);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check_all();
         if (cpu_en) en_cnt++;
      end
   endtask

   initial begin
      int first;
      rstn      = 1'b0;
      debug_en  = 1'b0;
      step_btn  = 1'b0;
      int_btn   = 1'b0;
      burst_en  = 1'b0;
      burst_len = 16'd0;
      int_ack   = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_cycle",  cycle_cnt, 32'd0);
      rstn = 1'b1;

      // Free run
      tick(100);
      check("free_cycle_cnt", cycle_cnt, 32'd100);

      // Halt and single steps
      debug_en = 1'b1;
      tick(1);
      check("halt_entry", {31'd0, halted}, 32'd1);
      for (int p = 0; p < 2; p++) begin
         step_btn = 1'b1;
         en_cnt = 0;
         first = -1;
         for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cpu_en && first < 0) first = i;
         end
         check("step_width", en_cnt, 32'd1);
         check("step_latency", first, 32'd2);
         step_btn = 1'b0;
         tick(5);
      end

      // Bursts: len 5, len 0, len 10 with a re-press during the burst
      burst_en = 1'b1;
      burst_len = 16'd5;
      en_cnt = 0;
      step_btn = 1'b1; tick(3); step_btn = 1'b0; tick(17);
      check("burst5_len", en_cnt, 32'd5);
      check("burst5_halt", {31'd0, halted}, 32'd1);
      burst_len = 16'd0;
      en_cnt = 0;
      step_btn = 1'b1; tick(3); step_btn = 1'b0; tick(10);
      check("burst0_len", en_cnt, 32'd1);
      burst_len = 16'd10;
      en_cnt = 0;
      step_btn = 1'b1; tick(4); step_btn = 1'b0; tick(2);
      step_btn = 1'b1; tick(4); step_btn = 1'b0; tick(30);
      check("burst10_ignore_press", en_cnt, 32'd10);

      // Abort a long burst by leaving debug mode
      burst_len = 16'd1000;
      en_cnt = 0;
      step_btn = 1'b1;
      for (int i = 0; i < 50 && en_cnt < 10; i++) tick(1);
      check("abort_reach10", en_cnt, 32'd10);
      step_btn = 1'b0;
      debug_en = 1'b0;
      tick(1);
      check("abort_run", {31'd0, halted}, 32'd0);
      en_cnt = 0;
      tick(20);
      check("abort_free", en_cnt, 32'd20);
      debug_en = 1'b1;
      en_cnt = 0;
      tick(20);
      check("abort_discarded", en_cnt, 32'd0);

      // Interrupt handshake
      int_btn = 1'b1;
      tick(2);
      check("int_early", {31'd0, int_req}, 32'd0);
      tick(1);
      check("int_latency", {31'd0, int_req}, 32'd1);
      int_btn = 1'b0; tick(3);
      int_btn = 1'b1; tick(4);
      check("int_drop1", {24'd0, int_drop}, 32'd1);
      int_btn = 1'b0;
      int_ack = 1'b1; tick(1); int_ack = 1'b0;
      check("int_acked", {31'd0, int_req}, 32'd0);
      int_btn = 1'b1; tick(3); int_btn = 1'b0; tick(3);
      int_btn = 1'b1; tick(2);
      int_ack = 1'b1; tick(1); int_ack = 1'b0;
      check("int_ack_and_rise", {31'd0, int_req}, 32'd1);
      check("int_ack_no_drop", {24'd0, int_drop}, 32'd1);
      int_btn = 1'b0; tick(3);

      // Asynchronous reset in the middle of a burst
      burst_len = 16'd50;
      step_btn = 1'b1; tick(4); step_btn = 1'b0; tick(3);
      check("pre_reset_burst", {31'd0, cpu_en}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst_cpu_en",  {31'd0, cpu_en},  32'd1);
      check("arst_halted",  {31'd0, halted},  32'd0);
      check("arst_int_req", {31'd0, int_req}, 32'd0);
      check("arst_cycle",   cycle_cnt,        32'd0);
      check("arst_drop",    {24'd0, int_drop}, 32'd0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      check("post_rst_run", {31'd0, halted}, 32'd0);
      tick(3);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) debug_en = ~debug_en;
         if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
         if ($urandom_range(0, 9) == 0) burst_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) burst_len = 16'($urandom_range(0, 8));
         if ($urandom_range(0, 5) == 0) int_btn = ~int_btn;
         int_ack = ($urandom_range(0, 4) == 0);
         tick(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
